// File: rtl/seq_mult_16_bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier and its adder.
package seq_mult_16_bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int unsigned MUL_ITER  = 16;
  localparam int unsigned PRODUCT_W = 32;

endpackage

// File: rtl/cla_16_bit.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with group generate/propagate.
module cla_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;

    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    // Second level: group carries resolved directly from c_in, no ripple between groups.
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end

    sum   = p ^ c;
    c_out = gc[4];
  end

endmodule

// File: rtl/seq_mult_16_bit.sv
// Sequential unsigned 16x16 shift-add multiplier; one iteration per clock through cla_16_bit.
module seq_mult_16_bit
  import seq_mult_16_bit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [PRODUCT_W-1:0] product
);

  mult_state_t          state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PRODUCT_W-1:0] product_q, product_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 c_out;
  logic [PRODUCT_W-1:0] shifted;

  assign add_b = mq_q[0] ? mcand_q : '0;

  cla_16_bit u_cla (
    .a     (acc_q),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // The adder carry lands in acc's MSB, so the 33-bit partial sum is never truncated.
  assign shifted = {c_out, sum, mq_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          count_d = '0;
        end
      end
      RUN: begin
        {acc_d, mq_d} = shifted;
        count_d       = count_q + 1'b1;
        if (count_q == CNT_W'(MUL_ITER - 1)) begin
          state_d   = DONE;
          product_d = shifted;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_16_bit.sv
// Self-checking bench for seq_mult_16_bit: timeline model compared every cycle plus directed literals.
module tb_seq_mult_16_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        ready, busy, done;
  logic [31:0] product;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seq_mult_16_bit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1..16 = iterating, 17 = result cycle.
  int          phase;
  logic [15:0] la, lb;
  logic [31:0] m_prod;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= 0;
      m_prod <= 32'd0;
    end else if (phase == 0) begin
      if (start) begin
        phase <= 1;
        la    <= a;
        lb    <= b;
      end
    end else if (phase < 16) begin
      phase <= phase + 1;
    end else if (phase == 16) begin
      phase  <= 17;
      m_prod <= {16'd0, la} * {16'd0, lb};
    end else begin
      phase <= 0;
    end
  end

  always @(negedge clk) begin
    check("ready", {31'd0, ready}, {31'd0, (phase == 0)});
    check("busy",  {31'd0, busy},  {31'd0, (phase >= 1 && phase <= 16)});
    check("done",  {31'd0, done},  {31'd0, (phase == 17)});
    check("product", product, m_prod);
  end

  int lat;
  int last_done;
  int ndone;

  // Drives start for one cycle; returns negedges from the drive cycle until done (40 = timeout).
  task automatic launch_and_wait(input logic [15:0] av, input logic [15:0] bv, output int l);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] lit);
    int l;
    launch_and_wait(av, bv, l);
    check({name, "_latency"}, l, 17);
    check({name, "_product"}, product, lit);
    check({name, "_model"}, m_prod, lit);
    @(negedge clk);
    check({name, "_ready_back"}, {31'd0, ready}, 32'd1);
    check({name, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op("basic", 16'd3, 16'd5, 32'd15);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("zero", 16'h1234, 16'h0000, 32'd0);
    run_op("ident", 16'h1234, 16'h0001, 32'h00001234);

    // Ignored starts: one during RUN, one in the DONE cycle.
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (lat < 5) begin @(negedge clk); lat++; end
    a = 16'd2; b = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat++;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    check("ign_latency", lat, 17);
    check("ign_product", product, 32'd63);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (25) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("ign_extra_done", ndone, 0);
    check("ign_idle", {31'd0, ready}, 32'd1);
    check("ign_product_hold", product, 32'd63);

    // Reset mid-operation.
    a = 16'h00FF; b = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (lat < 8) begin @(negedge clk); lat++; end
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_product", product, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    run_op("after_rst", 16'd100, 16'd200, 32'd20000);

    // Back-to-back with random operands.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] av, bv;
      int n;
      av = 16'($urandom);
      bv = 16'($urandom);
      if (i == 0) begin av = 16'hFFFF; bv = 16'h8001; end
      n = 0;
      while (!ready && n < 40) begin @(negedge clk); n++; end
      check("b2b_ready_wait", {31'd0, (n < 40)}, 32'd1);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      check("b2b_latency", lat, 17);
      check("b2b_product", product, {16'd0, av} * {16'd0, bv});
      if (i > 0) check("b2b_spacing", cyc - last_done, 18);
      last_done = cyc;
      @(negedge clk);
      check("b2b_done_width", {31'd0, done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
